// File: rtl/decode_stage.sv
// RV32I decode stage: combinational field/immediate decode plus optional first-illegal capture.
// Capture registers exist only when DECODE_ILLEGAL_CAPTURE_EN is defined.
module decode_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  output logic [4:0]  rd_address_o,
  output logic [4:0]  rs1_address_o,
  output logic [4:0]  rs2_address_o,
  output logic [31:0] immediate_o,
  output logic        illegal_o,
  output logic        illegal_seen_o,
  output logic [31:0] illegal_pc_o,
  output logic [31:0] illegal_instruction_o
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];
  assign f_rd   = instruction_i[11:7];
  assign f_rs1  = instruction_i[19:15];
  assign f_rs2  = instruction_i[24:20];

  assign i_imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign s_imm = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign b_imm = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                  instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign u_imm = {instruction_i[31:12], 12'b0};
  assign j_imm = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                  instruction_i[20], instruction_i[30:21], 1'b0};

  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_ill;

  always_comb begin
    dec_rd  = 5'd0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    dec_imm = 32'd0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_rd  = f_rd;
        dec_imm = u_imm;
      end
      OPC_AUIPC: begin
        dec_rd  = f_rd;
        dec_imm = pc_i + u_imm;
      end
      OPC_JAL: begin
        dec_rd  = f_rd;
        dec_imm = j_imm;
      end
      OPC_JALR: begin
        dec_rd  = f_rd;
        dec_rs1 = f_rs1;
        dec_imm = i_imm;
        dec_ill = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_imm = b_imm;
        dec_ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        dec_rd  = f_rd;
        dec_rs1 = f_rs1;
        dec_imm = i_imm;
        dec_ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_imm = s_imm;
        dec_ill = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec_rd  = f_rd;
        dec_rs1 = f_rs1;
        dec_imm = i_imm;
        // Shifts carry a bare shamt; bit 10 tags an arithmetic right shift.
        if (funct3 == 3'd1) begin
          dec_imm = {27'd0, f_rs2};
          dec_ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'b0000000)
            dec_imm = {27'd0, f_rs2};
          else if (funct7 == 7'b0100000)
            dec_imm = {21'd0, 1'b1, 5'd0, f_rs2};
          else
            dec_ill = 1'b1;
        end
      end
      OPC_OP: begin
        dec_rd  = f_rd;
        dec_rs1 = f_rs1;
        dec_rs2 = f_rs2;
        dec_ill = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OPC_MISC_MEM: dec_ill = (funct3 != 3'd0);
      OPC_SYSTEM:   dec_ill = (instruction_i != 32'h0000_0073) &&
                              (instruction_i != 32'h0010_0073);
      default:      dec_ill = 1'b1;
    endcase
    if (instruction_i[1:0] != 2'b11)
      dec_ill = 1'b1;
  end

  // Illegal instructions are squashed to a NOP for downstream stages.
  assign illegal_o     = dec_ill;
  assign rd_address_o  = dec_ill ? 5'd0  : dec_rd;
  assign rs1_address_o = dec_ill ? 5'd0  : dec_rs1;
  assign rs2_address_o = dec_ill ? 5'd0  : dec_rs2;
  assign immediate_o   = dec_ill ? 32'd0 : dec_imm;

`ifdef DECODE_ILLEGAL_CAPTURE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_seen_o        <= 1'b0;
      illegal_pc_o          <= 32'd0;
      illegal_instruction_o <= 32'd0;
    end else if (dec_ill && !illegal_seen_o) begin
      illegal_seen_o        <= 1'b1;
      illegal_pc_o          <= pc_i;
      illegal_instruction_o <= instruction_i;
    end
  end
`else
  logic unused_capture_inputs;
  assign unused_capture_inputs = clk_i ^ rst_ni;
  assign illegal_seen_o        = 1'b0;
  assign illegal_pc_o          = 32'd0;
  assign illegal_instruction_o = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors queue expectations, a negedge monitor checks.
// Capture expectations follow DECODE_ILLEGAL_CAPTURE_EN.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] instruction_i = 32'd0;
  logic [4:0]  rd_address_o, rs1_address_o, rs2_address_o;
  logic [31:0] immediate_o;
  logic        illegal_o;
  logic        illegal_seen_o;
  logic [31:0] illegal_pc_o, illegal_instruction_o;

  decode_stage dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .pc_i                  (pc_i),
    .instruction_i         (instruction_i),
    .rd_address_o          (rd_address_o),
    .rs1_address_o         (rs1_address_o),
    .rs2_address_o         (rs2_address_o),
    .immediate_o           (immediate_o),
    .illegal_o             (illegal_o),
    .illegal_seen_o        (illegal_seen_o),
    .illegal_pc_o          (illegal_pc_o),
    .illegal_instruction_o (illegal_instruction_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [47:0] dec;
    logic [64:0] cap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic v(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                   input logic ill);
    vecs.push_back('{pc, instr, rd, rs1, rs2, imm, ill});
  endtask

  function automatic logic [64:0] cap_exp(input logic seen, input logic [31:0] pc,
                                          input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_CAPTURE_EN
    return {seen, pc, ins};
`else
    return {1'b0, pc & 32'd0, ins & 32'd0} | {64'd0, seen & 1'b0};
`endif
  endfunction

  // Monitor: the decode is combinational, so a queued entry is due at the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("decode %h", e.instr),
            {rd_address_o, rs1_address_o, rs2_address_o, immediate_o, illegal_o}, e.dec);
        chk($sformatf("capture %h", e.instr),
            {illegal_seen_o, illegal_pc_o, illegal_instruction_o}, e.cap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        m_seen;
    logic [31:0] m_pc, m_ins;
    exp_t        e;
    int          k;

    v(32'h100, 32'h00000013, 0, 0, 0, 32'h0, 0);
    v(32'h104, 32'hFFF10093, 1, 2, 0, 32'hFFFFFFFF, 0);
    v(32'h108, 32'h00532423, 0, 6, 5, 32'h8, 0);
    v(32'h10C, 32'hFE208EE3, 0, 1, 2, 32'hFFFFFFFC, 0);
    v(32'h110, 32'hFE209EE3, 0, 1, 2, 32'hFFFFFFFC, 0);
    v(32'h114, 32'hABCDE3B7, 7, 0, 0, 32'hABCDE000, 0);
    v(32'h1000, 32'h12345197, 3, 0, 0, 32'h12346000, 0);
    v(32'hFFFFF000, 32'h12345197, 3, 0, 0, 32'h12344000, 0);
    v(32'h118, 32'hFFDFF0EF, 1, 0, 0, 32'hFFFFFFFC, 0);
    v(32'h11C, 32'h008000EF, 1, 0, 0, 32'h8, 0);
    v(32'h120, 32'hFF0100E7, 1, 2, 0, 32'hFFFFFFF0, 0);
    v(32'h124, 32'h00452283, 5, 10, 0, 32'h4, 0);
    v(32'h128, 32'h00521193, 3, 4, 0, 32'h5, 0);
    v(32'h12C, 32'h00525193, 3, 4, 0, 32'h5, 0);
    v(32'h130, 32'h41F25193, 3, 4, 0, 32'h41F, 0);
    v(32'h134, 32'h002081B3, 3, 1, 2, 32'h0, 0);
    v(32'h138, 32'h402081B3, 3, 1, 2, 32'h0, 0);
    v(32'h13C, 32'h4020D1B3, 3, 1, 2, 32'h0, 0);
    v(32'h140, 32'h0FF0000F, 0, 0, 0, 32'h0, 0);
    v(32'h144, 32'h00000073, 0, 0, 0, 32'h0, 0);
    v(32'h148, 32'h00100073, 0, 0, 0, 32'h0, 0);
    v(32'h80,  32'h00000000, 0, 0, 0, 32'h0, 1);
    v(32'h84,  32'h0000300F, 0, 0, 0, 32'h0, 1);
    v(32'h88,  32'hFF0110E7, 0, 0, 0, 32'h0, 1);
    v(32'h8C,  32'h00453283, 0, 0, 0, 32'h0, 1);
    v(32'h90,  32'h00456283, 0, 0, 0, 32'h0, 1);
    v(32'h94,  32'h00533423, 0, 0, 0, 32'h0, 1);
    v(32'h98,  32'hFE20AEE3, 0, 0, 0, 32'h0, 1);
    v(32'h9C,  32'h40521193, 0, 0, 0, 32'h0, 1);
    v(32'hA0,  32'h02525193, 0, 0, 0, 32'h0, 1);
    v(32'hA4,  32'h4020A1B3, 0, 0, 0, 32'h0, 1);
    v(32'hA8,  32'h022081B3, 0, 0, 0, 32'h0, 1);
    v(32'hAC,  32'h30001073, 0, 0, 0, 32'h0, 1);
    v(32'hB0,  32'h10000073, 0, 0, 0, 32'h0, 1);
    v(32'hB4,  32'h00000012, 0, 0, 0, 32'h0, 1);
    v(32'hB8,  32'h0000005B, 0, 0, 0, 32'h0, 1);
    v(32'hBC,  32'hFFF10093, 1, 2, 0, 32'hFFFFFFFF, 0);

    // Reset held with an illegal word present: nothing may be captured, decode still live.
    #12;
    chk("reset capture", {illegal_seen_o, illegal_pc_o, illegal_instruction_o}, 65'd0);
    chk("reset decode", {rd_address_o, rs1_address_o, rs2_address_o, immediate_o, illegal_o},
        48'd1);
    @(negedge clk_i);
    instruction_i = 32'h00000013;
    #2 rst_ni = 1'b1;

    m_seen = 1'b0;
    m_pc   = 32'd0;
    m_ins  = 32'd0;
    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1;
      pc_i          = vecs[i].pc;
      instruction_i = vecs[i].instr;
      e.instr = vecs[i].instr;
      e.dec   = {vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].ill};
      e.cap   = cap_exp(m_seen, m_pc, m_ins);
      sb.push_back(e);
      if (vecs[i].ill && !m_seen) begin
        m_seen = 1'b1;
        m_pc   = vecs[i].pc;
        m_ins  = vecs[i].instr;
      end
    end

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk_i);
      k++;
    end
    chk("scoreboard drained", 128'(sb.size()), 128'd0);

    // Mid-cycle reset pulse clears the capture without any clock edge.
    @(posedge clk_i);
    #1;
    pc_i          = 32'h300;
    instruction_i = 32'hFFF10093;
    chk("capture before pulse", {illegal_seen_o, illegal_pc_o, illegal_instruction_o},
        cap_exp(1'b1, 32'h80, 32'h0));
    #1 rst_ni = 1'b0;
    #1;
    chk("async clear", {illegal_seen_o, illegal_pc_o, illegal_instruction_o}, 65'd0);
    chk("decode in reset", {rd_address_o, rs1_address_o, rs2_address_o, immediate_o, illegal_o},
        {5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0});

    pc_i          = 32'h200;
    instruction_i = 32'h0000005B;
    @(posedge clk_i);
    #1;
    chk("hold in reset", {illegal_seen_o, illegal_pc_o, illegal_instruction_o}, 65'd0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("capture at release", {illegal_seen_o, illegal_pc_o, illegal_instruction_o},
        cap_exp(1'b1, 32'h200, 32'h0000005B));
    pc_i          = 32'h204;
    instruction_i = 32'h00000012;
    @(posedge clk_i);
    #1;
    chk("capture held", {illegal_seen_o, illegal_pc_o, illegal_instruction_o},
        cap_exp(1'b1, 32'h200, 32'h0000005B));
    chk("late illegal decode", {rd_address_o, rs1_address_o, rs2_address_o, immediate_o, illegal_o},
        48'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have the port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have the port pc_i, input, 32 bits: address of the instruction being decoded.
REQ-005 The block SHALL have the port instruction_i, input, 32 bits: RV32I instruction word.
REQ-006 The block SHALL have the ports rd_address_o, rs1_address_o and rs2_address_o, each output, 5 bits: destination and source register indices.
REQ-007 The block SHALL have the port immediate_o, output, 32 bits: operand immediate.
REQ-008 The block SHALL have the port illegal_o, output, 1 bit: the current instruction is not supported.
REQ-009 The block SHALL have the ports illegal_seen_o (1 bit), illegal_pc_o (32 bits) and illegal_instruction_o (32 bits), all outputs: first-illegal capture.

Function
REQ-010 rd/rs1/rs2/immediate/illegal SHALL be purely combinational functions of pc_i and instruction_i, with zero-cycle latency.
REQ-011 Field extraction SHALL be: rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20]; any field unused by the format SHALL be driven 0.
REQ-012 The outputs per opcode (instr[6:0]) SHALL be:
- LUI 0110111: rd; rs1 = rs2 = 0; imm = {instr[31:12], 12'b0}.
- AUIPC 0010111: rd; rs1 = rs2 = 0; imm = pc_i + U-imm, modulo 2^32.
- JAL 1101111: rd; rs1 = rs2 = 0; imm = sign-extended J-imm.
- JALR 1100111: rd, rs1; rs2 = 0; imm = I-imm.
- BRANCH 1100011: rd = 0; rs1, rs2; imm = sign-extended B-imm.
- LOAD 0000011: rd, rs1; rs2 = 0; imm = I-imm.
- STORE 0100011: rd = 0; rs1, rs2; imm = S-imm.
- OP-IMM 0010011: rd, rs1; rs2 = 0; imm = I-imm.
  - For SLLI, SRLI and SRAI, imm = zero-extended shamt instr[24:20], with bit 10 set for SRAI.
- OP 0110011: rd, rs1, rs2; imm = 0.
- MISC-MEM 0001111 and ECALL/EBREAK: all address outputs 0; imm = 0.
REQ-013 All immediates SHALL be sign-extended from instr[31], except U-imm and shamt.
REQ-014 illegal_o SHALL be 1 if any of the following holds:
- instr[1:0] != 2'b11;
- the opcode is not listed in REQ-012;
- JALR with funct3 != 0;
- BRANCH with funct3 = 2 or 3;
- LOAD with funct3 = 3, 6 or 7;
- STORE with funct3 > 2;
- OP with funct7 other than 0000000, or 0100000 only with funct3 = 0 or 5;
- OP-IMM shift with an invalid funct7;
- SYSTEM other than exactly 0x00000073 or 0x00100073 (CSR instructions are illegal).
REQ-015 When illegal_o is 1, rd, rs1 and rs2 SHALL be 0 and imm SHALL be 0, so the instruction behaves as a NOP downstream.
REQ-016 NOP 0x00000013 SHALL decode to all-zero outputs with illegal_o = 0.

Reset
REQ-017 Asserting rst_ni low SHALL immediately clear illegal_seen_o, illegal_pc_o and illegal_instruction_o to 0, independent of clk_i.
REQ-018 Deassertion of rst_ni SHALL be synchronised externally, and the combinational outputs SHALL NOT be affected by reset.

Configuration
REQ-019 With DECODE_ILLEGAL_CAPTURE_EN defined, the first rising edge with illegal_o = 1 and illegal_seen_o = 0 SHALL set illegal_seen_o = 1 and capture pc_i and instruction_i.
REQ-020 The captured values SHALL hold across later illegal instructions until reset.
REQ-021 An illegal instruction present on the same edge on which reset is released SHALL be captured.
REQ-022 Without DECODE_ILLEGAL_CAPTURE_EN, the three capture outputs SHALL be tied to 0, no flops SHALL be inferred, and clk_i SHALL be unused.

Verification
REQ-023 0xFFF10093 (ADDI x1,x2,-1) -> rd = 1, rs1 = 2, rs2 = 0, imm = 0xFFFFFFFF, illegal = 0.
REQ-024 0x00532423 (SW x5,8(x6)) -> rd = 0, rs1 = 6, rs2 = 5, imm = 0x00000008.
REQ-025 0xFE208EE3 (BEQ x1,x2,-4) -> rd = 0, rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC.
REQ-026 0xABCDE3B7 (LUI x7) -> rd = 7, imm = 0xABCDE000; 0x12345197 (AUIPC x3) at pc 0x1000 -> rd = 3, imm = 0x12346000.
REQ-027 0x00000000 at pc 0x80, then 0x0000300F at pc 0x84 -> illegal_o = 1 for both, all fields 0; with the macro, illegal_pc_o = 0x80, illegal_instruction_o = 0, seen = 1 after the first edge and unchanged after the second.
REQ-028 rst_ni pulsed low mid-clock after a capture -> capture outputs go to 0 without a clock edge; without the macro they stay 0 throughout.
